// File: rtl/conv_tile_accum.sv
`default_nettype none
// ============================================================================
// conv_tile_accum : pipelined Tm x Tn multiply-accumulate tile with saturating
//                   per-output-map accumulators, optional ReLU and result hold.
// Revision 1.0
// ============================================================================
module conv_tile_accum #(
  parameter int Tm_p   = 2,
  parameter int Tn_p   = 2,
  parameter int DW_p   = 8,
  parameter int AW_p   = 24,
  parameter int RELU_p = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        first_i,
  input  logic                        last_i,
  input  logic [Tm_p*Tn_p*DW_p-1:0]   weights_i,
  input  logic [Tm_p*Tn_p*DW_p-1:0]   fm_i,
  input  logic [Tm_p*AW_p-1:0]        fm_init_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [Tm_p*AW_p-1:0]        fm_o,
  output logic                        sat_o
);

  localparam int PW = 2 * DW_p;
  localparam int EW = AW_p + 2;
  localparam int NP = Tm_p * Tn_p;
  localparam logic signed [EW-1:0] c_MAX = {3'b000, {(AW_p-1){1'b1}}};
  localparam logic signed [EW-1:0] c_MIN = {3'b111, {(AW_p-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic w_accept;
  logic w_first;

  logic signed [PW-1:0]   w_prod [NP];
  logic signed [PW-1:0]   r_prod [NP];
  logic signed [AW_p-1:0] r_s1_init [Tm_p];
  logic                   r_s1_valid;
  logic                   r_s1_first;
  logic                   r_s1_last;
  logic                   r_s2_last;

  logic signed [AW_p-1:0] r_acc [Tm_p];
  logic signed [EW-1:0]   w_total [Tm_p];
  logic signed [EW-1:0]   w_clamp [Tm_p];
  logic [Tm_p-1:0]        w_lane_sat;
  logic                   r_sat;

  assign ready_o  = (r_state == IDLE) || (r_state == ACC);
  assign valid_o  = (r_state == DONE);
  assign sat_o    = r_sat;
  assign w_accept = valid_i && ready_o;
  // A beat landing in IDLE always starts a fresh accumulation.
  assign w_first  = first_i || (r_state == IDLE);

  generate
    for (genvar k = 0; k < NP; k++) begin : g_prod
      assign w_prod[k] = $signed(weights_i[k*DW_p +: DW_p]) * $signed(fm_i[k*DW_p +: DW_p]);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int k = 0; k < NP; k++) r_prod[k] <= '0;
      for (int m = 0; m < Tm_p; m++) r_s1_init[m] <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first;
        r_s1_last  <= last_i;
        for (int k = 0; k < NP; k++) r_prod[k] <= w_prod[k];
        for (int m = 0; m < Tm_p; m++) r_s1_init[m] <= $signed(fm_init_i[m*AW_p +: AW_p]);
      end
    end
  end

  // Sum is carried two bits wider than the accumulator so overflow is visible.
  always_comb begin
    for (int m = 0; m < Tm_p; m++) begin
      w_total[m] = r_s1_first ? {{2{r_s1_init[m][AW_p-1]}}, r_s1_init[m]}
                              : {{2{r_acc[m][AW_p-1]}}, r_acc[m]};
      for (int n = 0; n < Tn_p; n++) begin
        w_total[m] = w_total[m]
                   + {{(EW-PW){r_prod[m*Tn_p+n][PW-1]}}, r_prod[m*Tn_p+n]};
      end
      w_lane_sat[m] = 1'b0;
      w_clamp[m]    = w_total[m];
      if (w_total[m] > c_MAX) begin
        w_clamp[m]    = c_MAX;
        w_lane_sat[m] = 1'b1;
      end else if (w_total[m] < c_MIN) begin
        w_clamp[m]    = c_MIN;
        w_lane_sat[m] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s2_last <= 1'b0;
      for (int m = 0; m < Tm_p; m++) r_acc[m] <= '0;
    end else begin
      r_s2_last <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        for (int m = 0; m < Tm_p; m++) r_acc[m] <= w_clamp[m][AW_p-1:0];
      end
    end
  end

  // A new first beat wins over saturation from a run it is discarding.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sat <= 1'b0;
    end else if (w_accept && w_first) begin
      r_sat <= 1'b0;
    end else if (r_s1_valid && (|w_lane_sat)) begin
      r_sat <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = last_i ? DRAIN : ACC;
      ACC:     if (w_accept && last_i) w_next_state = DRAIN;
      DRAIN:   if (r_s2_last) w_next_state = DONE;
      DONE:    if (ready_i) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  generate
    for (genvar m = 0; m < Tm_p; m++) begin : g_lane
      if (RELU_p != 0) begin : g_relu
        assign fm_o[m*AW_p +: AW_p] = r_acc[m][AW_p-1] ? '0 : r_acc[m];
      end else begin : g_linear
        assign fm_o[m*AW_p +: AW_p] = r_acc[m];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_accum.sv
`default_nettype none
// ============================================================================
// tb_conv_tile_accum : directed + randomized checks of conv_tile_accum against
//                      a per-beat arithmetic reference model.
// Revision 1.0
// ============================================================================
module tb_conv_tile_accum;

  localparam int TM = 2;
  localparam int TN = 2;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                valid_i, first_i, last_i, ready_i;
  logic [TM*TN*DW-1:0] weights, fmap;
  logic [TM*AW-1:0]    init;
  logic                ready_o, valid_o, sat_o;
  logic                ready_o_r, valid_o_r, sat_o_r;
  logic [TM*AW-1:0]    fm_o, fm_o_r;

  conv_tile_accum #(.Tm_p(TM), .Tn_p(TN), .DW_p(DW), .AW_p(AW), .RELU_p(0)) u_dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .first_i(first_i), .last_i(last_i), .weights_i(weights), .fm_i(fmap),
    .fm_init_i(init), .valid_o(valid_o), .ready_i(ready_i), .fm_o(fm_o), .sat_o(sat_o)
  );

  conv_tile_accum #(.Tm_p(TM), .Tn_p(TN), .DW_p(DW), .AW_p(AW), .RELU_p(1)) u_dut_relu (
    .clk_i(clk), .reset_i(rst), .valid_i(valid_i), .ready_o(ready_o_r),
    .first_i(first_i), .last_i(last_i), .weights_i(weights), .fm_i(fmap),
    .fm_init_i(init), .valid_o(valid_o_r), .ready_i(ready_i), .fm_o(fm_o_r), .sat_o(sat_o_r)
  );

  int n_vec = 0;
  int n_err = 0;

  longint w   [TM][TN];
  longint f   [TM][TN];
  longint ini [TM];
  longint m_acc [TM];
  bit     m_active = 0;
  bit     m_sat    = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  function automatic longint lane(input logic [TM*AW-1:0] bus, input int m);
    logic signed [AW-1:0] v;
    v = bus[m*AW +: AW];
    return longint'(v);
  endfunction

  // Reference: one beat of the accumulation rule with saturation.
  task automatic model_beat(input bit fst);
    longint v;
    bit seed;
    seed = fst || !m_active;
    if (seed) m_sat = 0;
    for (int m = 0; m < TM; m++) begin
      v = seed ? ini[m] : m_acc[m];
      for (int n = 0; n < TN; n++) v += w[m][n] * f[m][n];
      if (v > MAXV) begin v = MAXV; m_sat = 1; end
      if (v < MINV) begin v = MINV; m_sat = 1; end
      m_acc[m] = v;
    end
    m_active = 1;
  endtask

  task automatic drive(input bit fst, input bit lst);
    for (int m = 0; m < TM; m++) begin
      for (int n = 0; n < TN; n++) begin
        weights[(m*TN+n)*DW +: DW] = DW'(w[m][n]);
        fmap[(m*TN+n)*DW +: DW]    = DW'(f[m][n]);
      end
      init[m*AW +: AW] = AW'(ini[m]);
    end
    valid_i = 1'b1;
    first_i = fst;
    last_i  = lst;
    check("ready_o_accepting", longint'(ready_o), 1);
    check("ready_o_relu_accepting", longint'(ready_o_r), 1);
    @(posedge clk);
    model_beat(fst);
    #1;
    valid_i = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, longint'(valid_o), 1);
    check({tag, "_ready_low"}, longint'(ready_o), 0);
    check({tag, "_sat"}, longint'(sat_o), longint'(m_sat));
    check({tag, "_sat_relu"}, longint'(sat_o_r), longint'(m_sat));
    for (int m = 0; m < TM; m++) begin
      check($sformatf("%s_lane%0d", tag, m), lane(fm_o, m), m_acc[m]);
      check($sformatf("%s_relu_lane%0d", tag, m), lane(fm_o_r, m), (m_acc[m] < 0) ? 0 : m_acc[m]);
    end
  endtask

  // Called right after the last beat's acceptance edge (+1).
  task automatic finish_txn(input string tag, input int hold);
    check({tag, "_lat_t0"}, longint'(valid_o), 0);
    check({tag, "_drain_ready"}, longint'(ready_o), 0);
    @(posedge clk); #1;
    check({tag, "_lat_t1"}, longint'(valid_o), 0);
    @(posedge clk); #1;
    check_result(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_result({tag, "_hold"});
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, "_xfer_valid"}, longint'(valid_o), 0);
    check({tag, "_xfer_ready"}, longint'(ready_o), 1);
    m_active = 0;
  endtask

  task automatic set_all(input longint wv, input longint fv, input longint i0, input longint i1);
    for (int m = 0; m < TM; m++)
      for (int n = 0; n < TN; n++) begin
        w[m][n] = wv;
        f[m][n] = fv;
      end
    ini[0] = i0;
    ini[1] = i1;
  endtask

  task automatic randomize_inputs();
    for (int m = 0; m < TM; m++) begin
      for (int n = 0; n < TN; n++) begin
        w[m][n] = longint'($urandom_range(0, 255)) - 128;
        f[m][n] = longint'($urandom_range(0, 255)) - 128;
      end
      ini[m] = longint'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; first_i = 0; last_i = 0; ready_i = 0;
    weights = '0; fmap = '0; init = '0;
    #12;
    check("rst_ready", longint'(ready_o), 1);
    check("rst_valid", longint'(valid_o), 0);
    check("rst_sat", longint'(sat_o), 0);
    check("rst_fm_o", longint'(fm_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single first+last beat.
    w[0][0] = 1; w[0][1] = 2; w[1][0] = 3; w[1][1] = 4;
    f[0][0] = 5; f[0][1] = 6; f[1][0] = 7; f[1][1] = 8;
    ini[0] = 10; ini[1] = -5;
    drive(1, 1);
    check("single_model0", m_acc[0], 27);
    finish_txn("single", 0);
    check("single_fm0_after", lane(fm_o, 0), 27);

    // Three consecutive beats.
    set_all(1, 2, 0, 0);
    drive(1, 0); drive(0, 0); drive(0, 1);
    finish_txn("three", 0);

    // ReLU pattern.
    set_all(1, 4, 0, 0);
    w[0][0] = -1; w[0][1] = -1;
    drive(1, 1);
    finish_txn("relu", 0);

    // Long saturating run.
    set_all(127, 127, 0, 0);
    for (int b = 0; b < 600; b++) drive(b == 0, b == 599);
    finish_txn("satrun", 0);

    // Held result under backpressure.
    randomize_inputs();
    drive(1, 0); drive(0, 1);
    finish_txn("hold", 5);

    // Reset between beats drops the partial result.
    randomize_inputs();
    drive(1, 0);
    #2 rst = 1'b1;
    #2;
    check("midrst_valid", longint'(valid_o), 0);
    check("midrst_ready", longint'(ready_o), 1);
    check("midrst_fm_o", longint'(fm_o), 0);
    check("midrst_sat", longint'(sat_o), 0);
    rst = 1'b0;
    m_active = 0; m_sat = 0;
    for (int m = 0; m < TM; m++) m_acc[m] = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_quiet", longint'(valid_o), 0);
    end
    randomize_inputs();
    drive(0, 1);
    finish_txn("postrst", 1);

    // Randomized transactions with reseeds, gaps and backpressure.
    for (int t = 0; t < 60; t++) begin
      int nb;
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++) begin
        bit fst;
        randomize_inputs();
        fst = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        drive(fst, b == nb - 1);
      end
      finish_txn($sformatf("rnd%0d", t), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/conv_tile_accum.md
CONV_TILE_ACCUM -- requirements
Module: conv_tile_accum

Interface
REQ-001 SHALL provide parameter Tm_p, default 2, output maps per tile (>=1).
REQ-002 SHALL provide parameter Tn_p, default 2, input maps per tile (>=1).
REQ-003 SHALL provide parameter DW_p, default 8, signed two's-complement width of weights and features.
REQ-004 SHALL provide parameter AW_p, default 24, signed accumulator/output width (>= 2*DW_p + clog2(Tn_p)).
REQ-005 SHALL provide parameter RELU_p, default 0; 1 clamps negative results to 0 at output.
REQ-006 clk_i  input  1  sole clock, all state on rising edge.
REQ-007 reset_i  input  1  asynchronous, active-high reset.
REQ-008 valid_i  input  1  input beat valid.
REQ-009 ready_o  output  1  block accepts a beat this cycle.
REQ-010 first_i  input  1  beat starts a new accumulation, seeding from fm_init_i.
REQ-011 last_i  input  1  beat is the final input tile of the accumulation.
REQ-012 weights_i  input  Tm_p*Tn_p*DW_p  weight [m][n].
REQ-013 fm_i  input  Tm_p*Tn_p*DW_p  input feature [m][n].
REQ-014 fm_init_i  input  Tm_p*AW_p  per-output-map seed (bias or partial sum).
REQ-015 valid_o  output  1  fm_o holds a completed result.
REQ-016 ready_i  input  1  downstream accepts result.
REQ-017 fm_o  output  Tm_p*AW_p  accumulated result per output map.
REQ-018 sat_o  output  1  some lane saturated during the current/held accumulation.

Function
REQ-019 A beat SHALL be accepted iff valid_i && ready_o on a rising edge; inputs are ignored otherwise.
REQ-020 Stage 1 SHALL register all Tm_p*Tn_p full-precision signed products weights[m][n]*fm[m][n], plus first/last flags, one cycle after acceptance.
REQ-021 Stage 2 SHALL, one cycle later, sum the Tn_p products of lane m and add to acc[m] (or to fm_init_i[m] sampled at acceptance when first), saturating to signed AW_p range.
REQ-022 Saturation SHALL clamp to +2^(AW_p-1)-1 / -2^(AW_p-1) and set sat_o, which stays set until the next first beat is accepted or reset.
REQ-023 FSM states: IDLE (no accumulation), ACC (accumulating), DRAIN (last accepted, pipeline flushing), DONE (result held).
REQ-024 IDLE->ACC on accepted beat without last_i; IDLE/ACC->DRAIN on accepted beat with last_i; DRAIN->DONE when the last beat leaves stage 2; DONE->IDLE on ready_i.
REQ-025 A beat accepted in IDLE SHALL be treated as first regardless of first_i.
REQ-026 first_i in ACC SHALL discard the running sum and reseed from fm_init_i; no result emitted for the discarded run.
REQ-027 ready_o SHALL be 1 in IDLE and ACC, 0 in DRAIN and DONE.
REQ-028 Back-to-back beats SHALL be accepted every cycle in ACC (throughput 1 beat/cycle).
REQ-029 valid_o SHALL be 1 exactly in DONE; fm_o and sat_o SHALL be stable while valid_o && !ready_i.
REQ-030 Latency: last beat accepted at edge t -> valid_o high after edge t+2.
REQ-031 With RELU_p=1, fm_o[m] SHALL be 0 for negative acc[m]; sat_o unaffected by clamping.
REQ-032 valid_o && ready_i SHALL complete the transfer; the next beat is accepted no earlier than the following cycle.

Reset
REQ-033 reset_i high SHALL immediately force IDLE, ready_o=1, valid_o=0, sat_o=0, fm_o=0, all accumulators and pipeline registers 0.
REQ-034 Reset mid-accumulation or in DONE SHALL drop the partial/held result with no output beat.

Verification (Tm_p=2, Tn_p=2, DW_p=8, AW_p=16)
REQ-035 Single beat first+last, w={{1,2},{3,4}}, fm={{5,6},{7,8}}, init={10,-5} -> fm_o={27,48}, valid_o at t+2.
REQ-036 Three consecutive beats w=all 1, fm=all 2, init=0 -> ready_o high all three, fm_o={12,12}.
REQ-037 Accumulate w=fm=all 127 for 600 beats -> lane clamps to 32767, sat_o=1.
REQ-038 RELU_p=1, w={{-1,-1},{1,1}}, fm=all 4 -> fm_o={0,8}.
REQ-039 Hold ready_i=0 for 5 cycles in DONE -> fm_o/valid_o stable, ready_o=0, then one transfer and IDLE.
REQ-040 Assert reset_i between beats 1 and 2 -> valid_o stays 0; fresh beat afterward yields result with no prior contribution.
